// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - Command, program byte stream and imem write port of the loader
// The master side issues load commands and program bytes; the slave side is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err_len;

    modport master (
        output start, load_len, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err_len
    );

    modport slave (
        input  start, load_len, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err_len
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Boot loader: clears imem to NOP, streams a program in, then releases the pipeline
// All outputs are registered from the next state except in_ready, decoded from the state register.
module imem_loader #(
    parameter int         ADDR_W      = 9,
    parameter int         DEPTH       = 512,
    parameter logic [7:0] FILL_BYTE   = 8'h90,
    parameter int         HOLD_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_V   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_HOLD,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_len_q, err_len_d;
    logic              start_ok, start_bad;

    assign start_ok  = bus.start && (bus.load_len <= DEPTH_V);
    assign start_bad = bus.start && (bus.load_len > DEPTH_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_len_q   <= err_len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        hold_d      = hold_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_len_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_CLEAR;
                    len_d   = bus.load_len;
                    cnt_d   = '0;
                end else if (start_bad) begin
                    err_len_d = 1'b1;
                end
            end
            S_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q[ADDR_W-1:0];
                mem_wdata_d = FILL_BYTE;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    hold_d  = '0;
                    state_d = (len_q != '0) ? S_LOAD : S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD: begin
                // in_ready is implied by the state, so in_valid alone completes the handshake
                if (bus.in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = bus.in_data;
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        hold_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_rst_d = (state_d != S_DONE);
        busy_d    = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_HOLD);
        done_d    = (state_d == S_DONE);
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - Self-checking bench for imem_loader against a write-sequence and memory-image model
module tb_imem_loader;
    localparam int         ADDR_W      = 9;
    localparam int         DEPTH       = 512;
    localparam logic [7:0] FILL        = 8'h90;
    localparam int         HOLD_CYCLES = 4;
    localparam int         BUDGET      = 5000;

    logic clk;
    logic rst;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .FILL_BYTE  (FILL),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]        prog   [DEPTH];
    logic [7:0]        tb_mem [DEPTH];
    logic [ADDR_W-1:0] wr_a   [$];
    logic [7:0]        wr_d   [$];
    int                cyc = 0;
    int                last_wr_cyc = -1;
    int                rst_fall_cyc = -1;
    int                rdy_cnt = 0;
    logic              prev_cpu_rst = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.mem_we === 1'b1) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
            tb_mem[bus.mem_addr] = bus.mem_wdata;
            last_wr_cyc = cyc;
        end
        if (bus.in_ready === 1'b1) rdy_cnt++;
        if (prev_cpu_rst === 1'b1 && bus.cpu_rst === 1'b0) rst_fall_cyc = cyc;
        prev_cpu_rst = bus.cpu_rst;
    end

    task automatic clear_monitor();
        wr_a.delete();
        wr_d.delete();
        for (int a = 0; a < DEPTH; a++) tb_mem[a] = 8'hxx;
        last_wr_cyc  = -1;
        rst_fall_cyc = -1;
        rdy_cnt      = 0;
    endtask

    task automatic start_load(input int len);
        clear_monitor();
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.load_len = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    // pct < 0 selects the fixed valid pattern 1,0,0,1,0,1 starting at the first LOAD cycle
    task automatic drive_bytes(input int len, input int pct, input int stop_at);
        int   idx;
        int   pi;
        int   n;
        logic hs;
        logic v;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        pi  = 0;
        n   = 0;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
        while (idx < stop_at && n < BUDGET) begin
            @(negedge clk);
            n++;
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            if (bus.in_ready && idx < len) begin
                v = (pct < 0) ? pat[pi % 6] : ($urandom_range(0, 99) < pct);
                pi++;
                bus.in_valid = v;
                bus.in_data  = v ? prog[idx] : 8'($urandom);
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom);
            end
        end
        n_chk++;
        if (idx != stop_at) begin
            n_fail++;
            $display("FAIL drive_bytes: accepted %0d bytes, expected %0d within %0d cycles", idx, stop_at, BUDGET);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done=%b after %0d cycles, expected 1", tag, bus.done, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_load(input string tag, input int len);
        int           bad;
        int           exp_n;
        logic [7:0]   exp_b;
        exp_n = DEPTH + len;
        n_chk++;
        if (wr_a.size() != exp_n) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, wr_a.size(), exp_n);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= wr_a.size()) bad++;
            else if (wr_a[i] !== ADDR_W'(i) || wr_d[i] !== FILL) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s fill_seq: %0d bad fill writes, expected 0", tag, bad);
        end
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (DEPTH + i >= wr_a.size()) bad++;
            else if (wr_a[DEPTH+i] !== ADDR_W'(i) || wr_d[DEPTH+i] !== prog[i]) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s prog_seq: %0d bad program writes, expected 0", tag, bad);
        end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_b = (a < len) ? prog[a] : FILL;
            if (tb_mem[a] !== exp_b) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s mem_image: %0d bytes differ, expected 0", tag, bad);
        end
        n_chk++;
        if (rst_fall_cyc - last_wr_cyc != HOLD_CYCLES) begin
            n_fail++;
            $display("FAIL %s hold_gap: cpu_rst fell %0d cycles after last write, expected %0d",
                     tag, rst_fall_cyc - last_wr_cyc, HOLD_CYCLES);
        end
        n_chk++;
        if (bus.cpu_rst !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state: cpu_rst=%b busy=%b done=%b in_ready=%b, expected 0 0 1 0",
                     tag, bus.cpu_rst, bus.busy, bus.done, bus.in_ready);
        end
    endtask

    task automatic full_load(input string tag, input int len, input int pct);
        start_load(len);
        drive_bytes(len, pct, len);
        wait_done(tag);
        check_load(tag, len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: cpu_rst=%b in_ready=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b, expected 1 0 0 000 00 0 0 0",
                     bus.cpu_rst, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err_len);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b cpu_rst=%b we=%b, expected 0 1 0", bus.busy, bus.cpu_rst, bus.mem_we);
        end
    endtask

    task automatic test_cold_boot();
        prog[0] = 8'hB8; prog[1] = 8'hEF; prog[2] = 8'hBE; prog[3] = 8'hAD; prog[4] = 8'hDE;
        full_load("cold_boot", 5, 100);
    endtask

    task automatic test_restart_from_done();
        prog[0] = 8'($urandom);
        start_load(1);
        n_chk++;
        if (bus.cpu_rst !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_edge: cpu_rst=%b busy=%b done=%b, expected 1 1 0", bus.cpu_rst, bus.busy, bus.done);
        end
        drive_bytes(1, 100, 1);
        wait_done("restart");
        check_load("restart", 1);
    endtask

    task automatic test_zero_len();
        full_load("zero_len", 0, 100);
        n_chk++;
        if (rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_len in_ready: high for %0d cycles, expected 0", rdy_cnt);
        end
        n_chk++;
        if (tb_mem[0] !== FILL) begin
            n_fail++;
            $display("FAIL zero_len mem0: got %h expected %h", tb_mem[0], FILL);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
        full_load("gapped", 3, -1);
    endtask

    task automatic check_err(input string tag, input logic exp_done);
        n_chk++;
        if (bus.err_len !== 1'b1 || bus.busy !== 1'b0 || bus.done !== exp_done) begin
            n_fail++;
            $display("FAIL %s err_pulse: err=%b busy=%b done=%b, expected 1 0 %b", tag, bus.err_len, bus.busy, bus.done, exp_done);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL %s err_width: err=%b on second cycle, expected 0", tag, bus.err_len);
        end
        repeat (20) @(negedge clk);
        n_chk++;
        if (wr_a.size() != 0 || bus.busy !== 1'b0 || bus.done !== exp_done) begin
            n_fail++;
            $display("FAIL %s err_quiet: writes=%0d busy=%b done=%b, expected 0 0 %b", tag, wr_a.size(), bus.busy, bus.done, exp_done);
        end
    endtask

    task automatic test_err_len();
        start_load($urandom_range(DEPTH + 1, 2 * DEPTH - 1));
        check_err("err_done", 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_load(DEPTH + 1);
        check_err("err_idle", 1'b0);
        prog[0] = 8'($urandom);
        prog[1] = 8'($urandom);
        full_load("after_err", 2, 100);
    endtask

    task automatic test_rst_mid_load();
        for (int i = 0; i < 5; i++) prog[i] = 8'($urandom);
        start_load(5);
        drive_bytes(5, 100, 2);
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.mem_we !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.mem_addr !== '0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_load: we=%b cpu_rst=%b in_ready=%b busy=%b addr=%h done=%b, expected 0 1 0 0 000 0",
                     bus.mem_we, bus.cpu_rst, bus.in_ready, bus.busy, bus.mem_addr, bus.done);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        full_load("reload", 5, 100);
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) prog[i] = 8'($urandom);
            full_load("random", len, $urandom_range(30, 100));
        end
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
        full_load("full_depth", DEPTH, 90);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.load_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_cold_boot();
        test_restart_from_done();
        test_zero_len();
        test_gapped();
        test_err_len();
        test_rst_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
